mem_stage_ctrl: RTL and testbench

Memory-stage consumer of the decode control bundle (memread, memwrite, byteword, regwrite, memtoreg) as it arrives at the M stage.
- Issues data-memory accesses over a req/ack handshake.
- Performs byte-lane steering and load extraction.
- Stalls the upstream pipeline while an access is outstanding.
- Registers the write-back bundle for the WB stage.

---
 rtl/mem_stage_ctrl.sv | 177 +++++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ctrl.sv
// ============================================================================
// mem_stage_ctrl : M-stage data-memory access controller with req/ack
//                  handshake, byte-lane steering, load extraction and WB regs.
// Optional: MEM_ALIGN_CHECK_EN enables misaligned word-access detection.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_stage_ctrl #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              memread,
   input  logic              memwrite,
   input  logic              byteword,
   input  logic              regwrite_in,
   input  logic              memtoreg_in,
   input  logic [ADDR_W-1:0] alu_result,
   input  logic [DATA_W-1:0] store_data,
   input  logic [4:0]        dest_in,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   output logic [3:0]        dmem_be,
   input  logic [DATA_W-1:0] dmem_rdata,
   input  logic              dmem_ack,
   output logic              stall,
   output logic              wb_regwrite,
   output logic [4:0]        wb_dest,
   output logic [DATA_W-1:0] wb_data,
   output logic              misalign
);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } state_t;

   state_t r_state, w_state_nxt;

   logic              r_req, r_we, r_wb_regwrite, r_misalign;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata, r_wb_data;
   logic [3:0]        r_be;
   logic [4:0]        r_wb_dest;

   logic              w_access, w_is_load, w_mis_chk;
   logic              w_stall, w_issue, w_retire, w_misalign, w_wb_pass;
   logic [1:0]        w_lane;
   logic [3:0]        w_be;
   logic [DATA_W-1:0] w_wdata, w_load_data;
   logic [7:0]        w_lane_byte;

   assign w_access  = memread | memwrite;
   // A load without memtoreg is illegal but still executed as a load.
   assign w_is_load = memread & ~memwrite & (memtoreg_in | memread);
   assign w_lane    = alu_result[1:0];

`ifdef MEM_ALIGN_CHECK_EN
   assign w_mis_chk = w_access & byteword & (w_lane != 2'b00);
`else
   assign w_mis_chk = 1'b0;
`endif

   always_comb begin
      w_be    = 4'hF;
      w_wdata = store_data;
      if (!byteword) begin
         w_be    = 4'b0001 << w_lane;
         w_wdata = {4{store_data[7:0]}};
      end
   end

   always_comb begin
      w_lane_byte = 8'h00;
      case (w_lane)
         2'd0:    w_lane_byte = dmem_rdata[7:0];
         2'd1:    w_lane_byte = dmem_rdata[15:8];
         2'd2:    w_lane_byte = dmem_rdata[23:16];
         default: w_lane_byte = dmem_rdata[31:24];
      endcase
      w_load_data = byteword ? dmem_rdata : {{(DATA_W-8){w_lane_byte[7]}}, w_lane_byte};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_stall     = 1'b0;
      w_issue     = 1'b0;
      w_retire    = 1'b0;
      w_misalign  = 1'b0;
      w_wb_pass   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_access) begin
               if (w_mis_chk) begin
                  w_misalign = 1'b1;
               end else begin
                  w_stall     = 1'b1;
                  w_issue     = 1'b1;
                  w_state_nxt = S_BUSY;
               end
            end else begin
               w_wb_pass = 1'b1;
            end
         end
         default: begin
            w_stall = ~dmem_ack;
            if (dmem_ack) begin
               w_retire    = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_req         <= 1'b0;
         r_we          <= 1'b0;
         r_addr        <= '0;
         r_wdata       <= '0;
         r_be          <= 4'h0;
         r_wb_regwrite <= 1'b0;
         r_wb_dest     <= 5'd0;
         r_wb_data     <= '0;
         r_misalign    <= 1'b0;
      end else begin
         r_misalign <= w_misalign;
         if (w_issue) begin
            r_req         <= 1'b1;
            r_we          <= memwrite;
            r_addr        <= {alu_result[ADDR_W-1:2], 2'b00};
            r_be          <= w_be;
            r_wdata       <= w_wdata;
            r_wb_regwrite <= 1'b0;
         end
         if (w_retire) begin
            r_req         <= 1'b0;
            r_we          <= 1'b0;
            r_wb_regwrite <= w_is_load & regwrite_in;
            r_wb_dest     <= dest_in;
            r_wb_data     <= w_is_load ? w_load_data : alu_result;
         end
         if (w_misalign) begin
            r_wb_regwrite <= 1'b0;
         end
         if (w_wb_pass) begin
            r_wb_regwrite <= regwrite_in;
            r_wb_dest     <= dest_in;
            r_wb_data     <= alu_result;
         end
      end
   end

   // Stall is forced low while reset is asserted, independent of the inputs.
   assign stall       = w_stall & reset;
   assign dmem_req    = r_req;
   assign dmem_we     = r_we;
   assign dmem_addr   = r_addr;
   assign dmem_wdata  = r_wdata;
   assign dmem_be     = r_be;
   assign wb_regwrite = r_wb_regwrite;
   assign wb_dest     = r_wb_dest;
   assign wb_data     = r_wb_data;
   assign misalign    = r_misalign;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage_ctrl.sv
// ============================================================================
// tb_mem_stage_ctrl : directed self-checking bench for mem_stage_ctrl.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_stage_ctrl;

   logic        clk;
   logic        reset;
   logic        memread, memwrite, byteword, regwrite_in, memtoreg_in;
   logic [31:0] alu_result, store_data, dmem_rdata;
   logic [4:0]  dest_in;
   logic        dmem_ack;
   logic        dmem_req, dmem_we, stall, wb_regwrite, misalign;
   logic [31:0] dmem_addr, dmem_wdata, wb_data;
   logic [3:0]  dmem_be;
   logic [4:0]  wb_dest;

   int checks   = 0;
   int failures = 0;

   mem_stage_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .reset(reset),
      .memread(memread), .memwrite(memwrite), .byteword(byteword),
      .regwrite_in(regwrite_in), .memtoreg_in(memtoreg_in),
      .alu_result(alu_result), .store_data(store_data), .dest_in(dest_in),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_rdata(dmem_rdata),
      .dmem_ack(dmem_ack), .stall(stall), .wb_regwrite(wb_regwrite),
      .wb_dest(wb_dest), .wb_data(wb_data), .misalign(misalign)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      memread = 0; memwrite = 0; byteword = 0; regwrite_in = 0; memtoreg_in = 0;
      alu_result = 0; store_data = 0; dest_in = 0; dmem_ack = 0; dmem_rdata = 0;
   endtask

   int          stall_cnt, rw_cnt, stable;
   logic [31:0] h_addr, h_wdata;
   logic [3:0]  h_be;

   initial begin
      reset = 0;
      clear_inputs();
      #2;
      chk("rst_req", {31'd0, dmem_req}, 32'd0);
      chk("rst_be", {28'd0, dmem_be}, 32'd0);
      chk("rst_addr", dmem_addr, 32'd0);
      chk("rst_wb_rw", {31'd0, wb_regwrite}, 32'd0);
      chk("rst_stall", {31'd0, stall}, 32'd0);
      chk("rst_misalign", {31'd0, misalign}, 32'd0);
      @(negedge clk);
      reset = 1;

      // ALU pass-through in IDLE
      regwrite_in = 1; dest_in = 5; alu_result = 32'h55;
      #1 chk("alu_stall", {31'd0, stall}, 32'd0);
      tick();
      chk("alu_wb_rw", {31'd0, wb_regwrite}, 32'd1);
      chk("alu_wb_dest", {27'd0, wb_dest}, 32'd5);
      chk("alu_wb_data", wb_data, 32'h55);

      // Word load, ack in first BUSY cycle
      memread = 1; byteword = 1; memtoreg_in = 1; regwrite_in = 1; dest_in = 7; alu_result = 32'h100;
      #1 chk("wl_stall_idle", {31'd0, stall}, 32'd1);
      tick();
      chk("wl_req", {31'd0, dmem_req}, 32'd1);
      chk("wl_we", {31'd0, dmem_we}, 32'd0);
      chk("wl_addr", dmem_addr, 32'h100);
      chk("wl_be", {28'd0, dmem_be}, 32'hF);
      chk("wl_bubble", {31'd0, wb_regwrite}, 32'd0);
      dmem_ack = 1; dmem_rdata = 32'hDEADBEEF;
      #1 chk("wl_stall_ack", {31'd0, stall}, 32'd0);
      tick();
      chk("wl_req_drop", {31'd0, dmem_req}, 32'd0);
      chk("wl_wb_rw", {31'd0, wb_regwrite}, 32'd1);
      chk("wl_wb_dest", {27'd0, wb_dest}, 32'd7);
      chk("wl_wb_data", wb_data, 32'hDEADBEEF);
      clear_inputs();

      // Byte load from lane 3, sign-extended
      memread = 1; byteword = 0; memtoreg_in = 1; regwrite_in = 1; dest_in = 3; alu_result = 32'h103;
      tick();
      chk("bl_addr", dmem_addr, 32'h100);
      chk("bl_be", {28'd0, dmem_be}, 32'h8);
      dmem_ack = 1; dmem_rdata = 32'h80FF0000;
      tick();
      chk("bl_wb_data", wb_data, 32'hFFFFFF80);
      chk("bl_wb_rw", {31'd0, wb_regwrite}, 32'd1);

      // Byte store to lane 1
      clear_inputs();
      memwrite = 1; byteword = 0; regwrite_in = 1; alu_result = 32'h101; store_data = 32'h12345678;
      tick();
      chk("bs_we", {31'd0, dmem_we}, 32'd1);
      chk("bs_be", {28'd0, dmem_be}, 32'h2);
      chk("bs_wdata", dmem_wdata, 32'h78787878);
      chk("bs_addr", dmem_addr, 32'h100);
      dmem_ack = 1;
      tick();
      chk("bs_wb_rw", {31'd0, wb_regwrite}, 32'd0);
      chk("bs_we_drop", {31'd0, dmem_we}, 32'd0);
      clear_inputs();

      // Ack delayed by five BUSY cycles
      memread = 1; byteword = 1; memtoreg_in = 1; regwrite_in = 1; dest_in = 9; alu_result = 32'h204;
      stall_cnt = 0; rw_cnt = 0; stable = 1;
      #1 if (stall) stall_cnt++;
      tick();
      h_addr = dmem_addr; h_be = dmem_be; h_wdata = dmem_wdata;
      for (int i = 0; i < 5; i++) begin
         if (stall) stall_cnt++;
         if (wb_regwrite) rw_cnt++;
         if (!dmem_req || dmem_addr !== h_addr || dmem_be !== h_be || dmem_wdata !== h_wdata)
            stable = 0;
         tick();
      end
      dmem_ack = 1; dmem_rdata = 32'hCAFEF00D;
      #1 if (stall) stall_cnt++;
      tick();
      if (wb_regwrite) rw_cnt++;
      chk("dl_wb_data", wb_data, 32'hCAFEF00D);
      clear_inputs();
      tick();
      if (wb_regwrite) rw_cnt++;
      chk("dl_stall_cycles", stall_cnt, 32'd6);
      chk("dl_wb_writes", rw_cnt, 32'd1);
      chk("dl_stable", stable, 32'd1);

      // memread and memwrite together: store wins, no register write
      memread = 1; memwrite = 1; byteword = 1; memtoreg_in = 1; regwrite_in = 1;
      alu_result = 32'h10; store_data = 32'hA5A5A5A5;
      tick();
      chk("rw_we", {31'd0, dmem_we}, 32'd1);
      chk("rw_wdata", dmem_wdata, 32'hA5A5A5A5);
      dmem_ack = 1;
      tick();
      chk("rw_wb_rw", {31'd0, wb_regwrite}, 32'd0);
      clear_inputs();

      // Reset pulse mid-BUSY, then a late ack
      memread = 1; byteword = 1; memtoreg_in = 1; regwrite_in = 1; dest_in = 4; alu_result = 32'h300;
      tick();
      chk("rb_req", {31'd0, dmem_req}, 32'd1);
      #1 reset = 0; memread = 0; regwrite_in = 0;
      #1;
      chk("rb_req_async", {31'd0, dmem_req}, 32'd0);
      chk("rb_addr_async", dmem_addr, 32'd0);
      chk("rb_stall", {31'd0, stall}, 32'd0);
      @(negedge clk);
      reset = 1;
      dmem_ack = 1; dmem_rdata = 32'h99999999; alu_result = 32'h77;
      tick();
      chk("rb_late_req", {31'd0, dmem_req}, 32'd0);
      chk("rb_late_wb_rw", {31'd0, wb_regwrite}, 32'd0);
      chk("rb_late_wb_data", wb_data, 32'h77);
      clear_inputs();

      // Word load at a misaligned address
      memread = 1; byteword = 1; memtoreg_in = 1; regwrite_in = 1; dest_in = 2; alu_result = 32'h102;
`ifdef MEM_ALIGN_CHECK_EN
      #1 chk("ma_stall", {31'd0, stall}, 32'd0);
      tick();
      chk("ma_flag", {31'd0, misalign}, 32'd1);
      chk("ma_req", {31'd0, dmem_req}, 32'd0);
      chk("ma_wb_rw", {31'd0, wb_regwrite}, 32'd0);
      clear_inputs();
      tick();
      chk("ma_flag_pulse", {31'd0, misalign}, 32'd0);
      chk("ma_req_after", {31'd0, dmem_req}, 32'd0);
`else
      #1 chk("ma_stall", {31'd0, stall}, 32'd1);
      tick();
      chk("ma_req", {31'd0, dmem_req}, 32'd1);
      chk("ma_addr_trunc", dmem_addr, 32'h100);
      chk("ma_flag", {31'd0, misalign}, 32'd0);
      dmem_ack = 1; dmem_rdata = 32'h11223344;
      tick();
      chk("ma_wb_data", wb_data, 32'h11223344);
      clear_inputs();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
